fft_unload: RTL and testbench

- Reader end of the FFT result memory.
- The input side writes samples to RAM at bit-reversed addresses, and the in-place FFT leaves results in natural order.
- This block reads the result RAM sequentially, bin 0 to last, and streams the bins out over a valid/ready interface to the downstream spectrum/peak logic.
- It hides the 1-cycle synchronous RAM read latency and absorbs backpressure without dropping or duplicating bins.

---
 rtl/fft_unload.sv | 156 +++++++++++++++
 tb/tb_fft_unload.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_unload.sv
// fft_unload: reads the FFT result RAM in natural order (bin 0 to last) and
// streams the bins over valid/ready. A 2-entry skid FIFO plus an in-flight
// read slot absorbs the 1-cycle RAM latency and downstream backpressure.
// Optional feature macro: FFT_HALF_EN streams only the lower half of the bins
// (real-input frames); when undefined all 2^N bins are streamed.
module fft_unload #(
  parameter int unsigned N = 9,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         ram_ren,
  output logic [N-1:0] ram_addr,
  input  logic [W-1:0] ram_rdata_re,
  input  logic [W-1:0] ram_rdata_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [N-1:0] out_idx,
  output logic         out_last,
  output logic         done
);

`ifdef FFT_HALF_EN
  localparam int unsigned NBINS = 1 << (N - 1);
`else
  localparam int unsigned NBINS = 1 << N;
`endif
  localparam logic [N:0]   LastCnt = (N+1)'(NBINS - 1);
  localparam logic [N-1:0] LastIdx = N'(NBINS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e         state_q;
  logic [N:0]     icnt_q;       // number of reads issued this frame
  logic           pend_q;       // RAM data for the previous read is on ram_rdata_* now
  logic [N-1:0]   pend_idx_q;   // address of that pending read
  logic [1:0]     cnt_q;        // entries held in the skid FIFO
  logic           wr_q;
  logic           rd_q;
  logic [W-1:0]   mem_re_q  [2];
  logic [W-1:0]   mem_im_q  [2];
  logic [N-1:0]   mem_idx_q [2];

  logic           pop;
  logic           push;
  logic           deq;
  logic [1:0]     cnt_d;
  logic           can_issue;
  logic [W-1:0]   head_re;
  logic [W-1:0]   head_im;
  logic [N-1:0]   head_idx;

  // Head selection: stored entries are older than the returning RAM word, so
  // the RAM data is presented directly only while the FIFO is empty.
  always_comb begin
    out_valid = (cnt_q != 2'd0) | pend_q;
    if (cnt_q == 2'd0) begin
      head_re  = ram_rdata_re;
      head_im  = ram_rdata_im;
      head_idx = pend_idx_q;
    end else begin
      head_re  = mem_re_q[rd_q];
      head_im  = mem_im_q[rd_q];
      head_idx = mem_idx_q[rd_q];
    end
    out_re   = out_valid ? head_re  : '0;
    out_im   = out_valid ? head_im  : '0;
    out_idx  = out_valid ? head_idx : '0;
    out_last = out_valid & (head_idx == LastIdx);
  end

  // FIFO bookkeeping and the issue rule: after this edge, stored entries plus
  // the read currently on the RAM port plus a new read must not exceed two.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = pend_q & ~((cnt_q == 2'd0) & pop);
    deq       = pop & (cnt_q != 2'd0);
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, deq};
    can_issue = (cnt_d + {1'b0, ram_ren}) < 2'd2;
  end

  // Control FSM: start accept, read issue, flush and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_ren    <= 1'b0;
      ram_addr   <= '0;
      icnt_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      done       <= 1'b0;
      ram_ren    <= 1'b0;
      pend_q     <= ram_ren;
      pend_idx_q <= ram_addr;
      unique case (state_q)
        StIdle: begin
          // FIFO is empty here, so the first read can go out immediately.
          if (start) begin
            state_q  <= StRun;
            busy     <= 1'b1;
            ram_ren  <= 1'b1;
            ram_addr <= '0;
            icnt_q   <= (N+1)'(1);
          end
        end
        StRun: begin
          if (can_issue) begin
            ram_ren  <= 1'b1;
            ram_addr <= icnt_q[N-1:0];
            icnt_q   <= icnt_q + 1'b1;
            if (icnt_q == LastCnt) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (pop && out_last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Skid FIFO storage: capture returning RAM words that are not consumed on arrival.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_re_q[i]  <= '0;
        mem_im_q[i]  <= '0;
        mem_idx_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_re_q[wr_q]  <= ram_rdata_re;
        mem_im_q[wr_q]  <= ram_rdata_im;
        mem_idx_q[wr_q] <= pend_idx_q;
        wr_q            <= ~wr_q;
      end
      if (deq) rd_q <= ~rd_q;
    end
  end

endmodule

// File: tb/tb_fft_unload.sv
// tb_fft_unload: randomized bench for fft_unload with N=3. A synchronous RAM
// model returns re=3*addr, im=~addr; a reference model expects bins 0..NB-1
// in order, one done pulse per frame and at most two outstanding reads.
module tb_fft_unload;
  localparam int N = 3;
  localparam int W = 16;
`ifdef FFT_HALF_EN
  localparam int NB = 4;
`else
  localparam int NB = 8;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         busy;
  logic         ram_ren;
  logic [N-1:0] ram_addr;
  logic [W-1:0] ram_rdata_re;
  logic [W-1:0] ram_rdata_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic [N-1:0] out_idx;
  logic         out_last;
  logic         done;

  fft_unload #(.N(N), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .ram_ren      (ram_ren),
    .ram_addr     (ram_addr),
    .ram_rdata_re (ram_rdata_re),
    .ram_rdata_im (ram_rdata_im),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model holding the FFT results.
  initial begin
    ram_rdata_re = '0;
    ram_rdata_im = '0;
  end
  always @(posedge clk) begin
    if (ram_ren) begin
      ram_rdata_re <= W'(3 * int'(ram_addr));
      ram_rdata_im <= ~W'(ram_addr);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference-model state for the current frame.
  int           issued, xfers, dones, first_hs, last_hs;
  logic         stall_prev;
  logic [W-1:0] p_re, p_im, e_re, e_im;
  logic [N-1:0] p_idx;
  logic         p_last;

  task automatic frame_init();
    issued     = 0;
    xfers      = 0;
    dones      = 0;
    first_hs   = -1;
    last_hs    = -100;
    stall_prev = 1'b0;
  endtask

  // Monitor sampled at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (ram_ren) begin
        check("raddr_order", 32'(ram_addr), issued);
        issued++;
        check("reads_max", issued <= NB, 1);
        check("outstanding", (issued - xfers) <= 2, 1);
      end
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_idx", 32'(out_idx), 32'(p_idx));
        check("hold_re", 32'(out_re), 32'(p_re));
        check("hold_im", 32'(out_im), 32'(p_im));
        check("hold_last", out_last, p_last);
      end
      stall_prev = out_valid && !out_ready;
      p_idx  = out_idx;
      p_re   = out_re;
      p_im   = out_im;
      p_last = out_last;
      if (!busy) check("idle_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        e_re = W'(3 * xfers);
        e_im = ~W'(xfers);
        check("bin_idx", 32'(out_idx), xfers);
        check("bin_re", 32'(out_re), 32'(e_re));
        check("bin_im", 32'(out_im), 32'(e_im));
        check("bin_last", out_last, xfers == NB - 1);
        if (xfers == 0) first_hs = cyc;
        if (out_last) last_hs = cyc;
        xfers++;
        check("bin_count", xfers <= NB, 1);
      end
      if (done) begin
        dones++;
        check("done_cycle", cyc, last_hs + 1);
        check("done_busy", busy, 0);
        check("done_bins", xfers, NB);
      end
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_ren"}, ram_ren, 0);
    check({pfx, "_addr"}, 32'(ram_addr), 0);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_re"}, 32'(out_re), 0);
    check({pfx, "_im"}, 32'(out_im), 0);
    check({pfx, "_idx"}, 32'(out_idx), 0);
    check({pfx, "_last"}, out_last, 0);
    check({pfx, "_done"}, done, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: random ready; mode 2: ready=1 plus starts while busy.
  task automatic run_to_done(input int mode);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else           out_ready = 1'b1;
      if (mode == 2) start = out_valid && ((out_idx == 3'd2) || out_last);
      else           start = 1'b0;
      @(posedge clk); #1;
      if (dones != 0) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("single_done", dones, 1);
    check("frame_bins", xfers, NB);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    frame_init();
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Latency and full-rate streaming.
    frame_init();
    out_ready = 1'b1;
    pulse_start();
    check("lat_ren", ram_ren, 1);
    check("lat_addr", 32'(ram_addr), 0);
    check("lat_busy", busy, 1);
    check("lat_valid0", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid1", out_valid, 1);
    run_to_done(0);
    check("no_bubble", last_hs - first_hs, NB - 1);

    // Random backpressure.
    for (int f = 0; f < 3; f++) begin
      frame_init();
      pulse_start();
      run_to_done(1);
    end

    // Starts while busy are ignored.
    frame_init();
    pulse_start();
    run_to_done(2);
    check("ign_reads", issued, NB);

    // Reset while stalled on bin 3.
    frame_init();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_idx == 3'd3) begin
        out_ready = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_idx", 32'(out_idx), 3);
    check("pre_rst_bins", xfers, 3);
    reset = 1'b0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rst_no_done", dones, 0);
    check("rst_idle", busy, 0);
    frame_init();
    pulse_start();
    run_to_done(0);

    // Long stall right after start, then full rate.
    frame_init();
    out_ready = 1'b0;
    pulse_start();
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("stall_reads", issued <= 2, 1);
    check("stall_valid", out_valid, 1);
    check("stall_idx", 32'(out_idx), 0);
    run_to_done(0);
    check("stall_b2b", last_hs - first_hs, NB - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
